// File: rtl/register_scoreboard.sv
// Register scoreboard: per-register pending-write counters between decode and writeback.
// Decode claims a destination register; writeback retires the claim when it commits.
// Optional build macro: SCOREBOARD_WB_BYPASS_EN. When it is defined, a same-cycle retire of
// the last outstanding write clears contention combinationally, so the register file must
// forward the write data through.
module register_scoreboard #(
    parameter int unsigned NUM_REGISTERS = 32,
    parameter int unsigned MAX_IN_FLIGHT = 3,
    localparam int unsigned REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS),
    localparam int unsigned COUNT_WIDTH = $clog2(MAX_IN_FLIGHT + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] register_read_1,
    output logic                               register_read_1_contended,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] register_read_2,
    output logic                               register_read_2_contended,
    input  logic                               claim_valid,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] claim_register,
    output logic                               claim_ready,
    input  logic                               retire_valid,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] retire_register,
    input  logic                               clear_all,
    output logic                               busy,
    output logic                               error
);

    localparam logic [COUNT_WIDTH-1:0] MaxCount = COUNT_WIDTH'(MAX_IN_FLIGHT);
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam logic [COUNT_WIDTH-1:0] OneCount = COUNT_WIDTH'(1);
`endif

    // Register 0 is hardwired zero, so it owns no counter.
    logic [COUNT_WIDTH-1:0] count_q [NUM_REGISTERS-1:1];
    logic [COUNT_WIDTH-1:0] count_d [NUM_REGISTERS-1:1];
    logic [COUNT_WIDTH-1:0] count_view [NUM_REGISTERS];
    logic                   error_q;
    logic                   error_d;

    // Full-range view of the counters with register 0 reading as zero.
    always_comb begin
        count_view[0] = '0;
        for (int unsigned r = 1; r < NUM_REGISTERS; r++) begin
            count_view[r] = count_q[r];
        end
    end

    // Saturating per-register update; every saturation event raises the sticky error.
    always_comb begin
        logic claim_hit;
        logic retire_hit;
        claim_hit  = 1'b0;
        retire_hit = 1'b0;
        error_d    = error_q;
        for (int unsigned r = 1; r < NUM_REGISTERS; r++) begin
            claim_hit  = claim_valid && (claim_register == REGISTER_INDEXING_WIDTH'(r));
            retire_hit = retire_valid && (retire_register == REGISTER_INDEXING_WIDTH'(r));
            count_d[r] = count_q[r];
            if (claim_hit && !retire_hit) begin
                if (count_q[r] < MaxCount) begin
                    count_d[r] = count_q[r] + 1'b1;
                end else begin
                    error_d = 1'b1;
                end
            end else if (retire_hit && !claim_hit) begin
                if (count_q[r] != '0) begin
                    count_d[r] = count_q[r] - 1'b1;
                end else begin
                    error_d = 1'b1;
                end
            end
            // Flush drops every claim but still lets saturation events flag error.
            if (clear_all) begin
                count_d[r] = '0;
            end
        end
    end

    // State registers with synchronous reset taking priority over all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 1; r < NUM_REGISTERS; r++) begin
                count_q[r] <= '0;
            end
            error_q <= 1'b0;
        end else begin
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    // Contention lookup from registered counts, optionally bypassed by a same-cycle retire.
    always_comb begin
        register_read_1_contended = (count_view[register_read_1] != '0);
        register_read_2_contended = (count_view[register_read_2] != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (retire_valid && (retire_register == register_read_1) &&
            (count_view[register_read_1] == OneCount)) begin
            register_read_1_contended = 1'b0;
        end
        if (retire_valid && (retire_register == register_read_2) &&
            (count_view[register_read_2] == OneCount)) begin
            register_read_2_contended = 1'b0;
        end
`endif
    end

    // Claim acceptance and aggregate status.
    always_comb begin
        claim_ready = (count_view[claim_register] < MaxCount);
        busy        = 1'b0;
        for (int unsigned r = 1; r < NUM_REGISTERS; r++) begin
            busy = busy | (count_q[r] != '0);
        end
    end

    assign error = error_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Self-checking bench for register_scoreboard: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a counter-array model.
module tb_register_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] register_read_1;
    logic       register_read_1_contended;
    logic [4:0] register_read_2;
    logic       register_read_2_contended;
    logic       claim_valid;
    logic [4:0] claim_register;
    logic       claim_ready;
    logic       retire_valid;
    logic [4:0] retire_register;
    logic       clear_all;
    logic       busy;
    logic       error;

    int errors = 0;
    int checks = 0;

    // Model state: outstanding writes per register and the sticky error.
    int cnt [32];
    bit err_m;

    always #5 clk = ~clk;

    register_scoreboard dut (
        .clk                       (clk),
        .rst                       (rst),
        .register_read_1           (register_read_1),
        .register_read_1_contended (register_read_1_contended),
        .register_read_2           (register_read_2),
        .register_read_2_contended (register_read_2_contended),
        .claim_valid               (claim_valid),
        .claim_register            (claim_register),
        .claim_ready               (claim_ready),
        .retire_valid              (retire_valid),
        .retire_register           (retire_register),
        .clear_all                 (clear_all),
        .busy                      (busy),
        .error                     (error)
    );

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
        end
    endtask

    function automatic bit model_contended(input int idx);
        bit c;
        c = (idx != 0) && (cnt[idx] != 0);
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (retire_valid && (int'(retire_register) == idx) && (cnt[idx] == 1)) c = 1'b0;
`endif
        return c;
    endfunction

    // Drive one cycle's inputs, let them settle, and compare every output to the model.
    task automatic drive(input bit r, input int rd1, input int rd2, input bit cv, input int cr,
                         input bit rv, input int rr, input bit clr);
        bit any;
        rst             = r;
        register_read_1 = 5'(rd1);
        register_read_2 = 5'(rd2);
        claim_valid     = cv;
        claim_register  = 5'(cr);
        retire_valid    = rv;
        retire_register = 5'(rr);
        clear_all       = clr;
        #2;
        any = 1'b0;
        foreach (cnt[i]) if (cnt[i] != 0) any = 1'b1;
        check("contended_1", register_read_1_contended, model_contended(rd1));
        check("contended_2", register_read_2_contended, model_contended(rd2));
        check("claim_ready", claim_ready, (cr == 0) || (cnt[cr] < 3));
        check("busy", busy, any);
        check("error", error, err_m);
    endtask

    // Advance one clock and apply the scoreboard rules to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            foreach (cnt[i]) cnt[i] = 0;
            err_m = 1'b0;
        end else begin
            int cr;
            int rr;
            cr = int'(claim_register);
            rr = int'(retire_register);
            if (!(claim_valid && retire_valid && cr == rr)) begin
                if (claim_valid && cr != 0) begin
                    if (cnt[cr] < 3) cnt[cr]++;
                    else err_m = 1'b1;
                end
                if (retire_valid && rr != 0) begin
                    if (cnt[rr] > 0) cnt[rr]--;
                    else err_m = 1'b1;
                end
            end
            if (clear_all) foreach (cnt[i]) cnt[i] = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int rd1);
        drive(1'b0, rd1, 31, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 5, 31, 1'b0, 0, 1'b0, 0, 1'b0);
        tick();
    endtask

    initial begin
        foreach (cnt[i]) cnt[i] = 0;
        err_m = 1'b0;
        @(negedge clk);

        // Reset state.
        do_reset();
        idle(5);
        check("rst_busy", busy, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_cont1", register_read_1_contended, 1'b0);
        check("rst_cont2", register_read_2_contended, 1'b0);
        check("rst_ready", claim_ready, 1'b1);

        // Claim x5 in cycle 0, retire in cycle 3.
        drive(1'b0, 5, 31, 1'b1, 5, 1'b0, 0, 1'b0);
        check("claim5_c0_cont", register_read_1_contended, 1'b0);
        check("claim5_c0_busy", busy, 1'b0);
        tick();
        idle(5);
        check("claim5_c1_cont", register_read_1_contended, 1'b1);
        check("claim5_c1_busy", busy, 1'b1);
        tick();
        idle(5);
        tick();
        drive(1'b0, 5, 31, 1'b0, 0, 1'b1, 5, 1'b0);
`ifdef SCOREBOARD_WB_BYPASS_EN
        check("retire5_c3_cont", register_read_1_contended, 1'b0);
`else
        check("retire5_c3_cont", register_read_1_contended, 1'b1);
`endif
        tick();
        idle(5);
        check("retire5_c4_cont", register_read_1_contended, 1'b0);
        check("retire5_c4_busy", busy, 1'b0);
        tick();

        // Saturate x7.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 7, 31, 1'b1, 7, 1'b0, 0, 1'b0);
            check("claim7_ready", claim_ready, 1'b1);
            tick();
        end
        drive(1'b0, 7, 31, 1'b1, 7, 1'b0, 0, 1'b0);
        check("claim7_full_ready", claim_ready, 1'b0);
        tick();
        idle(7);
        check("claim7_overflow_err", error, 1'b1);
        tick();
        drive(1'b0, 7, 31, 1'b0, 0, 1'b1, 7, 1'b0);
        tick();
        idle(7);
        check("err_sticky", error, 1'b1);
        tick();
        do_reset();

        // Simultaneous claim+retire of x9 at count 1 and count 0.
        drive(1'b0, 9, 31, 1'b1, 9, 1'b0, 0, 1'b0);
        tick();
        drive(1'b0, 9, 31, 1'b1, 9, 1'b1, 9, 1'b0);
        tick();
        idle(9);
        check("x9_both_at1_cont", register_read_1_contended, 1'b1);
        tick();
        drive(1'b0, 9, 31, 1'b0, 0, 1'b1, 9, 1'b0);
        tick();
        drive(1'b0, 9, 31, 1'b1, 9, 1'b1, 9, 1'b0);
        tick();
        idle(9);
        check("x9_both_at0_cont", register_read_1_contended, 1'b0);
        check("x9_both_at0_err", error, 1'b0);
        tick();

        // Register 0 is ignored; retire at zero flags error.
        drive(1'b0, 0, 0, 1'b1, 0, 1'b0, 0, 1'b0);
        tick();
        drive(1'b0, 0, 0, 1'b0, 0, 1'b1, 0, 1'b0);
        tick();
        idle(0);
        check("x0_cont", register_read_1_contended, 1'b0);
        check("x0_busy", busy, 1'b0);
        check("x0_err", error, 1'b0);
        tick();
        drive(1'b0, 12, 31, 1'b0, 0, 1'b1, 12, 1'b0);
        tick();
        idle(12);
        check("x12_underflow_err", error, 1'b1);
        tick();
        do_reset();

        // clear_all beats a same-cycle claim; rst beats claims.
        drive(1'b0, 3, 4, 1'b1, 3, 1'b0, 0, 1'b0);
        tick();
        drive(1'b0, 3, 4, 1'b1, 4, 1'b0, 0, 1'b0);
        tick();
        drive(1'b0, 8, 3, 1'b1, 8, 1'b0, 0, 1'b1);
        tick();
        drive(1'b0, 8, 3, 1'b0, 0, 1'b0, 0, 1'b0);
        check("clear_busy", busy, 1'b0);
        check("clear_cont8", register_read_1_contended, 1'b0);
        tick();
        drive(1'b0, 10, 31, 1'b1, 10, 1'b0, 0, 1'b0);
        tick();
        drive(1'b1, 10, 31, 1'b1, 11, 1'b0, 0, 1'b0);
        tick();
        idle(10);
        check("rst_claim_busy", busy, 1'b0);
        tick();

        // Randomized traffic on a narrow register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 99) == 0), $urandom_range(0, 7), $urandom_range(0, 7),
                  ($urandom_range(0, 99) < 50), $urandom_range(0, 7),
                  ($urandom_range(0, 99) < 45), $urandom_range(0, 7),
                  ($urandom_range(0, 99) < 2));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
